// File: rtl/dp_arb_pkg.sv
// rtl/dp_arb_pkg.sv - shared types, defaults and width helper for the datapath arbiter
package dp_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int DW_DEF       = 32;
    localparam int MAX_HOLD_DEF = 8;

    // ceil(log2(n)), never less than 1 so a 1-entry range still has a bit
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after last
module rr_pick
    import dp_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = clog2_min1(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    input  logic [N_REQ-1:0] excl,
    output logic [N_REQ-1:0] win,
    output logic             found
);

    logic [N_REQ-1:0] cand;
    int               idx;

    assign cand = req & ~excl;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!found && cand[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/datapath_arbiter.sv
// rtl/datapath_arbiter.sv - round-robin owner of the shared datapath load port with a hold limit
module datapath_arbiter
    import dp_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [2:0]          gnt_id,
    output logic                dp_en,
    output logic [DW-1:0]       dp_data,
    output logic                busy
);

    localparam int              IW        = clog2_min1(N_REQ);
    localparam int              HW        = clog2_min1(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0]   LAST_RST  = IW'(N_REQ - 1);

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n, win, excl;
    logic [IW-1:0]    last, last_n, win_idx, own_idx;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic             found, own_req, at_limit;

    assign own_req  = |(req & gnt);
    assign at_limit = (hold_cnt == HOLD_LAST);
    // the owner is masked out only when its hold budget is spent
    assign excl     = (state == GRANT && own_req && at_limit) ? gnt : '0;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req   (req),
        .last  (last),
        .excl  (excl),
        .win   (win),
        .found (found)
    );

    always_comb begin
        win_idx = '0;
        own_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) win_idx = IW'(i);
            if (gnt[i]) own_idx = IW'(i);
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        last_n  = last;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = win;
                    last_n  = win_idx;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    hold_n = '0;
                    if (found) begin
                        gnt_n  = win;
                        last_n = win_idx;
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (at_limit && found) begin
                    gnt_n  = win;
                    last_n = win_idx;
                    hold_n = '0;
                end else if (!at_limit) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last     <= LAST_RST;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            last     <= last_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        dp_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) dp_data = dp_data | req_data[i*DW +: DW];
        end
    end

    assign gnt_id = 3'(own_idx);
    assign dp_en  = |gnt;
    assign busy   = (state == GRANT);

endmodule

// File: doc/datapath_arbiter.md
# datapath_arbiter

Round-robin arbiter that shares one datapath register-load port between up to N ASM-derived control units. Each control unit raises a request and presents a 32-bit operand. The arbiter grants exactly one owner at a time, drives the shared load enable and operand, and bounds ownership with a hold limit so that no requester starves. It sits between the per-task control units and the single shared datapath.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 32, operand width
- MAX_HOLD, 8, maximum consecutive grant cycles per owner when others are waiting (≥1)
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset
- req  input  N_REQ  per-requester request level
- req_data  input  N_REQ*DW  operands, requester k at bits [k*DW +: DW]
- gnt  output  N_REQ  registered one-hot grant, all-zero when idle
- gnt_id  output  3  index of current owner, 0 when idle
- dp_en  output  1  shared datapath load enable (= |gnt)
- dp_data  output  DW  operand of current owner, 0 when idle
- busy  output  1  high in GRANT state

## Operation
- Reset (rst==0 at clk edge): state IDLE, gnt=0, gnt_id=0, dp_en=0, dp_data=0, busy=0, hold_cnt=0, last=N_REQ-1 (requester 0 has highest priority first).
- Priority: search order last+1, last+2, … wrapping mod N_REQ; first asserted req wins.
- IDLE: if any req is set, load gnt with the winner, last=winner, hold_cnt=0, go to GRANT; otherwise stay.
- GRANT, owner k:
  - req[k]=0 (release): if others are pending, grant the next winner directly (no idle bubble, hold_cnt=0); else gnt=0 and go to IDLE.
  - req[k]=1, hold_cnt==MAX_HOLD-1, others pending: forced rotate to the next winner excluding k; hold_cnt=0.
  - req[k]=1 otherwise: keep k; hold_cnt increments and saturates at MAX_HOLD-1.
- A single lone requester keeps the grant indefinitely.
- dp_data is a combinational mux of req_data selected by the registered gnt. A requester may change its operand while granted; dp_data follows it.
- Requests that arrive while another requester is granted are not latched. The requester must hold req until granted.

## Timing
- Grant latency: req rising at edge t → gnt visible after edge t+1 (one cycle), when the arbiter is idle.
- Release-to-next-grant: owner drops req before edge t → new gnt after edge t; zero dead cycles.
- Forced rotation: an owner with continuous req and a competitor waiting holds for exactly MAX_HOLD cycles.
- Simultaneous requests in IDLE: the round-robin order decides, starting after last.
- Reset mid-grant: the next edge clears everything; the owner loses its grant without notice.
- gnt is never non-one-hot. dp_en==busy in every cycle.

## Structure
- Package dp_arb_pkg holds:
  - state encoding (IDLE=0, GRANT=1)
  - default constants N_REQ_DEF, DW_DEF, MAX_HOLD_DEF
  - a function for ceil-log2 of the gnt_id width.
- Sub-module rr_pick (combinational): inputs req, last, and exclude mask; outputs one-hot win and found. It is instantiated once; the FSM supplies an exclude mask of k for forced rotation and 0 otherwise.

## Test plan
- Reset, then req=4'b0000 for 5 cycles → gnt=0, dp_en=0, busy=0 throughout.
- req=4'b0101 asserted together from idle after reset → cycle 1 gnt=0001 (dp_data=req_data[0]). Req 0 drops → next cycle gnt=0100 with no zero cycle.
- req[1] held continuously, req[3] held, MAX_HOLD=8 → gnt=0010 for exactly 8 cycles, then gnt=1000 for 8 cycles, alternating.
- Only req[2] held for 20 cycles → gnt=0100 for all 20 cycles, with no rotation.
- Owner 3 releases while req=4'b0011 → next grant 0001 (wraps past 3 to 0). Then 0 releases → 0010.
- rst=0 during GRANT with gnt=0100 → next cycle all outputs 0. After release, req=4'b1111 → gnt=0001.
